// File: rtl/slot_reel_engine.sv
// slot_reel_engine: multi-reel slot machine core.
//   One start button launches REELS symbol counters in a staggered sequence, START_GAP cycles
//   apart. Each reel is halted by its own stop button. Once every reel has started and stopped,
//   the result is judged. A win (all symbols equal) raises fever for FEVER_HOLD cycles, bumps a
//   saturating win counter and then clears the reels.
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-high, clears all state
//   start      - start button (level; rising edge acts, only in IDLE)
//   stop       - per-reel stop buttons (level; rising edge acts on a running reel)
//   reels      - reel k symbol at [k*SYM_W +: SYM_W]
//   run_stop   - OR of all reel run flags
//   running    - per-reel run flags
//   fever      - win indication
//   win_count  - saturating number of wins since reset
//   busy       - high whenever the engine is not idle
module slot_reel_engine #(
   parameter int unsigned REELS      = 3,
   parameter int unsigned SYM_W      = 3,
   parameter int unsigned START_GAP  = 16,
   parameter int unsigned FEVER_HOLD = 32,
   parameter int unsigned WIN_W      = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [REELS-1:0]       stop,
   output logic [REELS*SYM_W-1:0] reels,
   output logic                   run_stop,
   output logic [REELS-1:0]       running,
   output logic                   fever,
   output logic [WIN_W-1:0]       win_count,
   output logic                   busy
);

   localparam int unsigned IDX_W  = $clog2(REELS + 1);
   localparam int unsigned GAP_W  = (START_GAP > 1) ? $clog2(START_GAP) : 1;
   localparam int unsigned HOLD_W = (FEVER_HOLD > 1) ? $clog2(FEVER_HOLD) : 1;

   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(START_GAP - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FEVER_HOLD - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(REELS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSpinup,
      StSpin,
      StJudge,
      StWin
   } state_e;

   state_e                   state_q, state_d;
   logic                     start_dly_q, start_dly_d;
   logic [REELS-1:0]         stop_dly_q, stop_dly_d;
   logic [REELS*SYM_W-1:0]   reels_q, reels_d;
   logic [REELS-1:0]         running_q, running_d;
   logic                     fever_q, fever_d;
   logic [WIN_W-1:0]         win_count_q, win_count_d;
   logic [GAP_W-1:0]         gap_q, gap_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [HOLD_W-1:0]        hold_q, hold_d;

   logic                     start_edge;
   logic [REELS-1:0]         stop_edge;
   logic                     all_equal;

   always_comb begin
      state_d     = state_q;
      start_dly_d = start;
      stop_dly_d  = stop;
      reels_d     = reels_q;
      running_d   = running_q;
      fever_d     = fever_q;
      win_count_d = win_count_q;
      gap_d       = gap_q;
      idx_d       = idx_q;
      hold_d      = hold_q;

      start_edge = start & ~start_dly_q;
      stop_edge  = stop & ~stop_dly_q;

      all_equal = 1'b1;
      for (int k = 1; k < REELS; k++) begin
         if (reels_q[k*SYM_W +: SYM_W] != reels_q[0 +: SYM_W]) begin
            all_equal = 1'b0;
         end
      end

      // Running reels advance; a stop edge halts the reel and suppresses that cycle's step.
      // Edges on idle reels fall through and are forgotten.
      for (int k = 0; k < REELS; k++) begin
         if (running_q[k]) begin
            if (stop_edge[k]) begin
               running_d[k] = 1'b0;
            end else begin
               reels_d[k*SYM_W +: SYM_W] = reels_q[k*SYM_W +: SYM_W] + SYM_W'(1);
            end
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start_edge) begin
               running_d[0] = 1'b1;
               gap_d        = '0;
               idx_d        = IDX_W'(1);
               state_d      = StSpinup;
            end
         end
         StSpinup: begin
            if (gap_q == GAP_LAST) begin
               gap_d = '0;
               for (int k = 1; k < REELS; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     running_d[k] = 1'b1;
                  end
               end
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = StSpin;
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         StSpin: begin
            // Every reel has been launched here, so all flags low means all stopped.
            if (running_q == '0) begin
               state_d = StJudge;
            end
         end
         StJudge: begin
            if (all_equal) begin
               fever_d = 1'b1;
               if (win_count_q != {WIN_W{1'b1}}) begin
                  win_count_d = win_count_q + WIN_W'(1);
               end
               hold_d  = '0;
               state_d = StWin;
            end else begin
               fever_d = 1'b0;
               state_d = StIdle;
            end
         end
         StWin: begin
            if (hold_q == HOLD_LAST) begin
               fever_d = 1'b0;
               reels_d = '0;
               state_d = StIdle;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         start_dly_q <= 1'b0;
         stop_dly_q  <= '0;
         reels_q     <= '0;
         running_q   <= '0;
         fever_q     <= 1'b0;
         win_count_q <= '0;
         gap_q       <= '0;
         idx_q       <= '0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         start_dly_q <= start_dly_d;
         stop_dly_q  <= stop_dly_d;
         reels_q     <= reels_d;
         running_q   <= running_d;
         fever_q     <= fever_d;
         win_count_q <= win_count_d;
         gap_q       <= gap_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
      end
   end

   assign reels     = reels_q;
   assign running   = running_q;
   assign run_stop  = |running_q;
   assign fever     = fever_q;
   assign win_count = win_count_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_slot_reel_engine.sv
// Randomised scoreboard bench for slot_reel_engine. A time-based reference model predicts
// the outputs after every clock edge; predictions are queued by the driver and popped and
// compared by an independent monitor. A second instance with a 2-bit win counter shares the
// stimulus to exercise saturation.
module tb_slot_reel_engine;

   localparam int R    = 3;
   localparam int SW   = 3;
   localparam int GAP  = 4;
   localparam int HOLD = 5;
   localparam int SYMS = 1 << SW;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [R-1:0]    stop  = '0;
   logic [R*SW-1:0] reels, reels_s;
   logic            run_stop, run_stop_s;
   logic [R-1:0]    running, running_s;
   logic            fever, fever_s;
   logic [7:0]      win_count;
   logic [1:0]      win_count_s;
   logic            busy, busy_s;

   always #5 clock = ~clock;

   slot_reel_engine #(.REELS(R), .SYM_W(SW), .START_GAP(GAP), .FEVER_HOLD(HOLD), .WIN_W(8)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .reels(reels),
      .run_stop(run_stop), .running(running), .fever(fever), .win_count(win_count), .busy(busy)
   );

   slot_reel_engine #(.REELS(R), .SYM_W(SW), .START_GAP(GAP), .FEVER_HOLD(HOLD), .WIN_W(2)) dut_s (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .reels(reels_s),
      .run_stop(run_stop_s), .running(running_s), .fever(fever_s), .win_count(win_count_s),
      .busy(busy_s)
   );

   typedef struct {
      logic [R*SW-1:0] reels;
      logic [R-1:0]    running;
      logic            run_stop;
      logic            fever;
      logic            busy;
      logic [7:0]      wc;
      logic [1:0]      wc_s;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: mode 0 idle, 1 spinning, 2 judging, 3 win. Reel k runs from edge
   // t0 + k*GAP until its stop edge.
   int        m_n = 0;
   int        m_mode = 0;
   int        m_t0 = 0;
   bit [R-1:0] m_stopped = '0;
   int        m_reel[R];
   int        m_left = 0;
   int        m_wins = 0;
   bit        m_pstart = 0;
   bit [R-1:0] m_pstop = '0;

   function automatic bit m_run_at(int k, int n);
      return (m_mode == 1) && (n >= m_t0 + k * GAP) && !m_stopped[k];
   endfunction

   function automatic void model_step();
      int n;
      bit se;
      bit [R-1:0] sedge;
      bit pre_run[R];
      bit any_run, eq;
      n = m_n + 1;
      if (reset) begin
         m_mode = 0; m_stopped = '0; m_wins = 0; m_pstart = 0; m_pstop = '0; m_left = 0;
         for (int k = 0; k < R; k++) m_reel[k] = 0;
         m_n = n;
         return;
      end
      se = start & !m_pstart;
      sedge = stop & ~m_pstop;
      m_pstart = start;
      m_pstop = stop;
      case (m_mode)
         0: if (se) begin m_mode = 1; m_t0 = n; m_stopped = '0; end
         1: begin
            any_run = 0;
            for (int k = 0; k < R; k++) begin
               pre_run[k] = m_run_at(k, n - 1);
               any_run |= pre_run[k];
            end
            for (int k = 0; k < R; k++) begin
               if (pre_run[k]) begin
                  if (sedge[k]) m_stopped[k] = 1;
                  else m_reel[k] = (m_reel[k] + 1) % SYMS;
               end
            end
            if ((n - 1 >= m_t0 + (R - 1) * GAP) && !any_run) m_mode = 2;
         end
         2: begin
            eq = 1;
            for (int k = 1; k < R; k++) if (m_reel[k] != m_reel[0]) eq = 0;
            if (eq) begin m_mode = 3; m_left = HOLD; m_wins++; end
            else m_mode = 0;
         end
         default: begin
            m_left--;
            if (m_left == 0) begin
               m_mode = 0;
               for (int k = 0; k < R; k++) m_reel[k] = 0;
            end
         end
      endcase
      m_n = n;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      for (int k = 0; k < R; k++) begin
         e.reels[k*SW +: SW] = SW'(m_reel[k]);
         e.running[k] = m_run_at(k, m_n);
      end
      e.run_stop = |e.running;
      e.fever = (m_mode == 3);
      e.busy = (m_mode != 0);
      e.wc = (m_wins > 255) ? 8'd255 : 8'(m_wins);
      e.wc_s = (m_wins > 3) ? 2'd3 : 2'(m_wins);
      return e;
   endfunction

   // One clock: predict the state after the coming edge, queue it, move to the next negedge.
   task automatic tick(int cycles = 1);
      for (int i = 0; i < cycles; i++) begin
         model_step();
         exp_q.push_back(model_out());
         @(negedge clock);
      end
   endtask

   task automatic bound_fail(string what);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired at %0t, model mode %0d", what, $time, m_mode);
   endtask

   task automatic press_stop(int k);
      stop[k] = 1'b1; tick();
      stop[k] = 1'b0; tick();
   endtask

   task automatic pulse_start();
      start = 1'b1; tick();
      start = 1'b0; tick();
   endtask

   // Press stop k so that reel k freezes on symbol v.
   task automatic stop_at(int k, int v);
      int cnt = 0;
      while (!(m_run_at(k, m_n) && m_reel[k] == v) && cnt < 300) begin
         tick();
         cnt++;
      end
      if (cnt >= 300) bound_fail("stop_at");
      else press_stop(k);
   endtask

   task automatic wait_mode(int mode);
      int cnt = 0;
      while (m_mode != mode && cnt < 100) begin
         tick();
         cnt++;
      end
      if (cnt >= 100) bound_fail("wait_mode");
   endtask

   task automatic do_reset();
      reset = 1'b1; tick();
      reset = 1'b0;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, want);
      end
   endtask

   exp_t mon_e;
   always @(posedge clock) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("reels", 32'(reels), 32'(mon_e.reels));
         chk("running", 32'(running), 32'(mon_e.running));
         chk("run_stop", 32'(run_stop), 32'(mon_e.run_stop));
         chk("fever", 32'(fever), 32'(mon_e.fever));
         chk("busy", 32'(busy), 32'(mon_e.busy));
         chk("win_count", 32'(win_count), 32'(mon_e.wc));
         chk("win_count_sat", 32'(win_count_s), 32'(mon_e.wc_s));
         chk("reels_sat_inst", 32'(reels_s), 32'(mon_e.reels));
         chk("fever_sat_inst", 32'(fever_s), 32'(mon_e.fever));
         chk("busy_sat_inst", 32'(busy_s), 32'(mon_e.busy));
         chk("run_stop_sat_inst", 32'(run_stop_s), 32'(mon_e.run_stop));
         chk("running_sat_inst", 32'(running_s), 32'(mon_e.running));
      end
   end

   initial begin
      int common, k0;
      for (int k = 0; k < R; k++) m_reel[k] = 0;

      // Buttons held through reset give exactly one edge afterwards.
      reset = 1'b1; start = 1'b1; stop = '1;
      tick(2);
      reset = 1'b0;
      tick(3);
      stop = '0;
      tick(3);
      start = 1'b0;
      for (int k = 0; k < R; k++) stop_at(k, int'($urandom_range(0, SYMS - 1)));
      wait_mode(0);

      // Stagger and wrap, then a loss at 5/2/6.
      pulse_start();
      tick(12);
      stop_at(0, 5); stop_at(1, 2); stop_at(2, 6);
      wait_mode(0);
      tick(3);

      // Win on 3s with start/stop activity during the fever window.
      pulse_start();
      stop_at(0, 3); stop_at(1, 3); stop_at(2, 3);
      wait_mode(3);
      pulse_start();
      press_stop(0);
      stop = '1; tick(); stop = '0;
      wait_mode(0);
      tick(2);

      // Early stop on reel2, held stop on reel1, second start during spin.
      start = 1'b1; tick(); start = 1'b0;
      press_stop(2);
      stop[1] = 1'b1;
      tick(10);
      pulse_start();
      stop_at(0, int'($urandom_range(0, SYMS - 1)));
      tick(4);
      stop[1] = 1'b0; tick();
      stop_at(1, int'($urandom_range(0, SYMS - 1)));
      stop_at(2, int'($urandom_range(0, SYMS - 1)));
      wait_mode(0);

      // Reset mid-spin and mid-win.
      pulse_start();
      tick(10);
      do_reset();
      tick(2);
      pulse_start();
      for (int k = 0; k < R; k++) stop_at(k, 1);
      wait_mode(3);
      tick(2);
      do_reset();
      tick(2);

      // Four wins: the 2-bit counter must stick at 3.
      for (int w = 0; w < 4; w++) begin
         pulse_start();
         for (int k = 0; k < R; k++) stop_at(k, (w * 3) % SYMS);
         wait_mode(0);
      end

      // Random rounds, some forced to a common symbol.
      for (int r = 0; r < 20; r++) begin
         pulse_start();
         common = int'($urandom_range(0, SYMS - 1));
         k0 = int'($urandom_range(0, R - 1));
         for (int i = 0; i < R; i++) begin
            if ($urandom_range(0, 2) != 0) stop_at((k0 + i) % R, common);
            else stop_at((k0 + i) % R, int'($urandom_range(0, SYMS - 1)));
         end
         wait_mode(0);
         tick(int'($urandom_range(0, 3)));
      end

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
